// File: rtl/victim_cache_ctrl_if.sv
// rtl/victim_cache_ctrl_if.sv - L1 request/response, tag-store and writeback signals of the victim cache controller
interface victim_cache_ctrl_if #(
  parameter int TAG_WIDTH = 4,
  parameter int NUM_WAYS  = 4
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_op;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 req_dirty;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_hit;
  logic [WAY_W-1:0]     rsp_way;
  logic                 rsp_dirty;

  logic                 ts_lookup_en;
  logic                 ts_read_en;
  logic                 ts_write_en;
  logic                 ts_valid_clear;
  logic                 ts_dirty_set;
  logic [TAG_WIDTH-1:0] ts_tag;
  logic [WAY_W-1:0]     ts_way;
  logic                 ts_hit;
  logic [WAY_W-1:0]     ts_hit_way;
  logic                 ts_valid_read;
  logic                 ts_dirty_read;
  logic [TAG_WIDTH-1:0] ts_tag_read;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [TAG_WIDTH-1:0] wb_tag;

  modport master (
    output req_valid, req_op, req_tag, req_dirty, rsp_ready,
           ts_hit, ts_hit_way, ts_valid_read, ts_dirty_read, ts_tag_read, wb_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_dirty,
           ts_lookup_en, ts_read_en, ts_write_en, ts_valid_clear, ts_dirty_set,
           ts_tag, ts_way, wb_valid, wb_tag
  );

  modport slave (
    input  req_valid, req_op, req_tag, req_dirty, rsp_ready,
           ts_hit, ts_hit_way, ts_valid_read, ts_dirty_read, ts_tag_read, wb_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_dirty,
           ts_lookup_en, ts_read_en, ts_write_en, ts_valid_clear, ts_dirty_set,
           ts_tag, ts_way, wb_valid, wb_tag
  );
endinterface

// File: rtl/victim_cache_ctrl.sv
// rtl/victim_cache_ctrl.sv - victim cache controller: PROBE extracts a line to L1, INSERT places an L1 victim
// with round-robin replacement and writeback of dirty victims.
module victim_cache_ctrl #(
  parameter int TAG_WIDTH = 4,
  parameter int NUM_WAYS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  victim_cache_ctrl_if.slave  bus
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EXTRACT, S_VREAD, S_WB, S_WRITE, S_DIRTY, S_RESP
  } state_t;

  state_t               state;
  logic                 op_q;
  logic                 dirty_q;
  logic                 ins_miss_q;
  logic                 hit_q;
  logic                 rsp_dirty_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [TAG_WIDTH-1:0] wb_tag_q;
  logic [WAY_W-1:0]     way_q;
  logic [WAY_W-1:0]     rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= 1'b0;
      dirty_q     <= 1'b0;
      ins_miss_q  <= 1'b0;
      hit_q       <= 1'b0;
      rsp_dirty_q <= 1'b0;
      tag_q       <= '0;
      wb_tag_q    <= '0;
      way_q       <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q        <= bus.req_op;
            tag_q       <= bus.req_tag;
            dirty_q     <= bus.req_dirty;
            hit_q       <= 1'b0;
            rsp_dirty_q <= 1'b0;
            ins_miss_q  <= 1'b0;
            way_q       <= '0;
            state       <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!op_q) begin
            // A PROBE miss responds with the all-zero flags set at accept.
            if (bus.ts_hit) begin
              way_q <= bus.ts_hit_way;
              state <= S_EXTRACT;
            end else begin
              state <= S_RESP;
            end
          end else if (bus.ts_hit) begin
            way_q <= bus.ts_hit_way;
            hit_q <= 1'b1;
            state <= S_WRITE;
          end else begin
            way_q      <= rr_ptr;
            ins_miss_q <= 1'b1;
            state      <= S_VREAD;
          end
        end
        S_EXTRACT: begin
          rsp_dirty_q <= bus.ts_dirty_read;
          hit_q       <= 1'b1;
          state       <= S_RESP;
        end
        S_VREAD: begin
          if (bus.ts_valid_read && bus.ts_dirty_read) begin
            wb_tag_q    <= bus.ts_tag_read;
            rsp_dirty_q <= 1'b1;
            state       <= S_WB;
          end else begin
            state <= S_WRITE;
          end
        end
        S_WB: begin
          if (bus.wb_ready) state <= S_WRITE;
        end
        S_WRITE: begin
          if (ins_miss_q) rr_ptr <= rr_ptr + 1'b1;
          state <= dirty_q ? S_DIRTY : S_RESP;
        end
        S_DIRTY: state <= S_RESP;
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Every output is forced low while rst is high, so nothing leaks in the reset cycle itself.
  logic run;
  assign run = !rst;

  assign bus.req_ready      = run && (state == S_IDLE);
  assign bus.rsp_valid      = run && (state == S_RESP);
  assign bus.rsp_hit        = run && hit_q;
  assign bus.rsp_way        = run ? way_q : '0;
  assign bus.rsp_dirty      = run && rsp_dirty_q;

  assign bus.ts_lookup_en   = run && (state == S_LOOKUP);
  assign bus.ts_read_en     = run && ((state == S_EXTRACT) || (state == S_VREAD));
  assign bus.ts_write_en    = run && (state == S_WRITE);
  assign bus.ts_valid_clear = run && (state == S_EXTRACT);
  assign bus.ts_dirty_set   = run && (state == S_DIRTY);
  assign bus.ts_tag         = (run && ((state == S_LOOKUP) || (state == S_WRITE))) ? tag_q : '0;
  assign bus.ts_way         = (run && ((state == S_EXTRACT) || (state == S_VREAD) ||
                                       (state == S_WRITE) || (state == S_DIRTY))) ? way_q : '0;

  assign bus.wb_valid       = run && (state == S_WB);
  assign bus.wb_tag         = (run && (state == S_WB)) ? wb_tag_q : '0;
endmodule

// File: tb/tb_victim_cache_ctrl.sv
// tb/tb_victim_cache_ctrl.sv - directed bench for victim_cache_ctrl with a behavioural 4-way tag store
module tb_victim_cache_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  victim_cache_ctrl_if #(.TAG_WIDTH(4), .NUM_WAYS(4)) bus ();
  victim_cache_ctrl #(.TAG_WIDTH(4), .NUM_WAYS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Behavioural tag store
  logic       m_valid [4];
  logic       m_dirty [4];
  logic [3:0] m_tag   [4];

  always_comb begin
    bus.ts_hit     = 1'b0;
    bus.ts_hit_way = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && (m_tag[i] == bus.ts_tag)) begin
        bus.ts_hit     = 1'b1;
        bus.ts_hit_way = 2'(i);
      end
    end
  end
  assign bus.ts_valid_read = m_valid[bus.ts_way];
  assign bus.ts_dirty_read = m_dirty[bus.ts_way];
  assign bus.ts_tag_read   = m_tag[bus.ts_way];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] <= 1'b0;
        m_dirty[i] <= 1'b0;
        m_tag[i]   <= 4'd0;
      end
    end else begin
      if (bus.ts_write_en) begin
        m_tag[bus.ts_way]   <= bus.ts_tag;
        m_valid[bus.ts_way] <= 1'b1;
        m_dirty[bus.ts_way] <= 1'b0;
      end
      if (bus.ts_valid_clear) begin
        m_valid[bus.ts_way] <= 1'b0;
        m_dirty[bus.ts_way] <= 1'b0;
      end
      if (bus.ts_dirty_set) m_dirty[bus.ts_way] <= 1'b1;
    end
  end

  // Event monitor and writeback back-pressure
  int         lookup_cnt = 0;
  int         read_cnt   = 0;
  int         wb_cnt     = 0;
  int         strobe_bad = 0;
  int         wb_run     = 0;
  int         wb_stall   = 0;
  logic [1:0] last_wr_way, last_ds_way, last_vc_way;
  logic [3:0] last_wr_tag, last_wb_tag;

  assign bus.wb_ready = (wb_run >= wb_stall);

  always @(posedge clk) begin
    if (bus.ts_lookup_en) lookup_cnt <= lookup_cnt + 1;
    if (bus.ts_read_en) read_cnt <= read_cnt + 1;
    if (bus.ts_write_en) begin
      last_wr_way <= bus.ts_way;
      last_wr_tag <= bus.ts_tag;
    end
    if (bus.ts_dirty_set) last_ds_way <= bus.ts_way;
    if (bus.ts_valid_clear) last_vc_way <= bus.ts_way;
    if (bus.wb_valid) begin
      wb_cnt      <= wb_cnt + 1;
      last_wb_tag <= bus.wb_tag;
    end
    wb_run <= (bus.wb_valid && !bus.wb_ready) ? wb_run + 1 : 0;
    if ((int'(bus.ts_lookup_en) + int'(bus.ts_read_en) + int'(bus.ts_write_en) + int'(bus.ts_dirty_set) > 1) ||
        (bus.ts_valid_clear && !bus.ts_read_en) ||
        ((bus.ts_lookup_en || bus.ts_read_en || bus.ts_write_en || bus.ts_dirty_set) &&
         (bus.req_ready || bus.rsp_valid || bus.wb_valid)))
      strobe_bad <= strobe_bad + 1;
  end

  logic       r_hit, r_dirty;
  logic [1:0] r_way;
  int         r_lat;

  // Returns with the response captured; completes the handshake only if rsp_ready is high.
  task automatic issue(input logic op, input logic [3:0] tag, input logic dirty);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_tag   = tag;
    bus.req_dirty = dirty;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    r_lat = 1;
    while (!bus.rsp_valid && r_lat < 60) begin
      @(posedge clk);
      #1;
      r_lat++;
    end
    r_hit   = bus.rsp_hit;
    r_way   = bus.rsp_way;
    r_dirty = bus.rsp_dirty;
    if (bus.rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [21:0] outs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {bus.req_ready, bus.rsp_valid, bus.wb_valid, bus.ts_lookup_en, bus.ts_read_en,
            bus.ts_write_en, bus.ts_valid_clear, bus.ts_dirty_set, bus.ts_tag, bus.ts_way,
            bus.rsp_hit, bus.rsp_way, bus.rsp_dirty, bus.wb_tag};
    tests++;
    if (outs !== 22'd0) begin fails++; $display("FAIL reset_outputs got %h want 0", outs); end
    rst = 1'b0;
    #1;
    tests++;
    if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_probe_miss();
    int lc0 = lookup_cnt;
    issue(1'b0, 4'h5, 1'b0);
    tests++;
    if (r_lat !== 2) begin fails++; $display("FAIL probe_miss_lat got %0d want 2", r_lat); end
    tests++;
    if ({r_hit, r_way, r_dirty} !== 4'b0000) begin
      fails++; $display("FAIL probe_miss_rsp got %b want 0000", {r_hit, r_way, r_dirty});
    end
    tests++;
    if (lookup_cnt - lc0 !== 1) begin fails++; $display("FAIL probe_miss_lookups got %0d want 1", lookup_cnt - lc0); end
  endtask

  task automatic test_fill_wrap();
    int wc0 = wb_cnt;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 4'(i + 1), 1'b0);
      tests++;
      if ({r_hit, r_way, r_dirty} !== {1'b0, 2'(i), 1'b0} || r_lat !== 4) begin
        fails++; $display("FAIL fill_way%0d got rsp=%b lat=%0d want rsp=%b lat=4", i, {r_hit, r_way, r_dirty}, r_lat, {1'b0, 2'(i), 1'b0});
      end
    end
    issue(1'b1, 4'h5, 1'b0);
    tests++;
    if (r_way !== 2'd0 || last_wr_tag !== 4'h5) begin
      fails++; $display("FAIL fill_wrap got way=%0d tag=%h want way=0 tag=5", r_way, last_wr_tag);
    end
    tests++;
    if (wb_cnt !== wc0) begin fails++; $display("FAIL fill_no_wb got %0d want %0d", wb_cnt, wc0); end
  endtask

  task automatic test_insert_hit(input logic [3:0] tag, input logic [1:0] way);
    int rc0 = read_cnt;
    int wc0 = wb_cnt;
    issue(1'b1, tag, 1'b1);
    tests++;
    if ({r_hit, r_way, r_dirty} !== {1'b1, way, 1'b0} || r_lat !== 4) begin
      fails++; $display("FAIL insert_hit_rsp got rsp=%b lat=%0d want rsp=%b lat=4", {r_hit, r_way, r_dirty}, r_lat, {1'b1, way, 1'b0});
    end
    tests++;
    if (read_cnt !== rc0 || wb_cnt !== wc0) begin
      fails++; $display("FAIL insert_hit_no_evict got reads=%0d wbs=%0d want 0 0", read_cnt - rc0, wb_cnt - wc0);
    end
    tests++;
    if (last_wr_way !== way || last_ds_way !== way) begin
      fails++; $display("FAIL insert_hit_ways got wr=%0d ds=%0d want %0d", last_wr_way, last_ds_way, way);
    end
  endtask

  task automatic test_dirty_wb();
    int wc0 = wb_cnt;
    wb_stall = 3;
    issue(1'b1, 4'h9, 1'b0);
    wb_stall = 0;
    tests++;
    if (r_lat !== 8) begin fails++; $display("FAIL dirty_wb_lat got %0d want 8", r_lat); end
    tests++;
    if ({r_hit, r_way, r_dirty} !== 4'b0011) begin
      fails++; $display("FAIL dirty_wb_rsp got %b want 0011", {r_hit, r_way, r_dirty});
    end
    tests++;
    if (wb_cnt - wc0 !== 4 || last_wb_tag !== 4'h2) begin
      fails++; $display("FAIL dirty_wb_bus got cycles=%0d tag=%h want 4 2", wb_cnt - wc0, last_wb_tag);
    end
    tests++;
    if (last_wr_way !== 2'd1 || last_wr_tag !== 4'h9) begin
      fails++; $display("FAIL dirty_wb_write got way=%0d tag=%h want 1 9", last_wr_way, last_wr_tag);
    end
  endtask

  task automatic test_probe_hit();
    issue(1'b0, 4'h3, 1'b0);
    tests++;
    if ({r_hit, r_way, r_dirty} !== 4'b1101 || r_lat !== 3) begin
      fails++; $display("FAIL probe_hit_rsp got rsp=%b lat=%0d want 1101 3", {r_hit, r_way, r_dirty}, r_lat);
    end
    tests++;
    if (last_vc_way !== 2'd2) begin fails++; $display("FAIL probe_hit_clear got %0d want 2", last_vc_way); end
    issue(1'b0, 4'h3, 1'b0);
    tests++;
    if ({r_hit, r_way, r_dirty} !== 4'b0000 || r_lat !== 2) begin
      fails++; $display("FAIL probe_again_rsp got rsp=%b lat=%0d want 0000 2", {r_hit, r_way, r_dirty}, r_lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] tags  [5] = '{4'h7, 4'h8, 4'hB, 4'hC, 4'hD};
    logic       dirts [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] ways  [5] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic       rdirt [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int         lats  [5] = '{5, 4, 4, 4, 6};
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, tags[i], dirts[i]);
      tests++;
      if ({r_hit, r_way, r_dirty} !== {1'b0, ways[i], rdirt[i]} || r_lat !== lats[i]) begin
        fails++; $display("FAIL b2b_%0d got rsp=%b lat=%0d want rsp=%b lat=%0d", i, {r_hit, r_way, r_dirty}, r_lat, {1'b0, ways[i], rdirt[i]}, lats[i]);
      end
    end
    tests++;
    if (last_wb_tag !== 4'h7 || last_ds_way !== 2'd2) begin
      fails++; $display("FAIL b2b_victim got wbtag=%h ds=%0d want 7 2", last_wb_tag, last_ds_way);
    end
  endtask

  task automatic test_rsp_hold();
    int n;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 4'hC, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_tag   = 4'hB;
    bus.req_dirty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_dirty, bus.req_ready} !== 6'b110100) begin
        fails++; $display("FAIL rsp_hold_%0d got %b want 110100", i, {bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_dirty, bus.req_ready});
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({bus.rsp_valid, bus.req_ready, bus.ts_lookup_en} !== 3'b010) begin
      fails++; $display("FAIL rsp_release got %b want 010", {bus.rsp_valid, bus.req_ready, bus.ts_lookup_en});
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    tests++;
    if (bus.ts_lookup_en !== 1'b1) begin fails++; $display("FAIL next_accept got %b want 1", bus.ts_lookup_en); end
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_way} !== 4'b1100) begin
      fails++; $display("FAIL held_req_rsp got %b want 1100", {bus.rsp_valid, bus.rsp_hit, bus.rsp_way});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_wb();
    int          n;
    int          wc0;
    logic [21:0] outs;
    issue(1'b1, 4'h8, 1'b1);
    tests++;
    if ({r_hit, r_way} !== 3'b111) begin fails++; $display("FAIL wb_setup got %b want 111", {r_hit, r_way}); end
    wb_stall = 1000;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b1;
    bus.req_tag   = 4'hF;
    bus.req_dirty = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.wb_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if ({bus.wb_valid, bus.wb_tag} !== 5'b11000) begin
      fails++; $display("FAIL wb_before_reset got %b want 11000", {bus.wb_valid, bus.wb_tag});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    outs = {bus.req_ready, bus.rsp_valid, bus.wb_valid, bus.ts_lookup_en, bus.ts_read_en,
            bus.ts_write_en, bus.ts_valid_clear, bus.ts_dirty_set, bus.ts_tag, bus.ts_way,
            bus.rsp_hit, bus.rsp_way, bus.rsp_dirty, bus.wb_tag};
    tests++;
    if (outs !== 22'd0) begin fails++; $display("FAIL wb_reset_outputs got %h want 0", outs); end
    wc0 = wb_cnt;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wb_stall = 0;
    #1;
    tests++;
    if ({bus.req_ready, bus.wb_valid} !== 2'b10) begin
      fails++; $display("FAIL wb_after_reset got %b want 10", {bus.req_ready, bus.wb_valid});
    end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (wb_cnt !== wc0 || bus.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL wb_not_reissued got wbs=%0d rsp_valid=%b want 0 0", wb_cnt - wc0, bus.rsp_valid);
    end
    issue(1'b0, 4'h8, 1'b0);
    tests++;
    if ({r_hit, r_way, r_dirty} !== 4'b0000 || r_lat !== 2) begin
      fails++; $display("FAIL post_reset_probe got rsp=%b lat=%0d want 0000 2", {r_hit, r_way, r_dirty}, r_lat);
    end
  endtask

  task automatic test_strobes();
    tests++;
    if (strobe_bad !== 0) begin fails++; $display("FAIL strobe_exclusive got %0d bad cycles want 0", strobe_bad); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_tag   = 4'd0;
    bus.req_dirty = 1'b0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_probe_miss();
    test_fill_wrap();
    test_insert_hit(4'h2, 2'd1);
    test_dirty_wb();
    test_insert_hit(4'h3, 2'd2);
    test_probe_hit();
    test_back_to_back();
    test_rsp_hold();
    test_reset_in_wb();
    test_strobes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
